// File: rtl/snp_capture_ctrl_if.sv
// Sample stream in, BRAM write port out, for the snapshot capture sequencer.
// The slave modport is the sequencer's view; the master modport is the data source and BRAM side.
interface snp_capture_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  trig;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_data;
  logic                  bram_we;

  modport master (output din, din_valid, trig, input bram_addr, bram_data, bram_we);
  modport slave  (input din, din_valid, trig, output bram_addr, bram_data, bram_we);
endinterface

// File: rtl/snp_capture_ctrl.sv
// Snapshot capture sequencer: arms on a software edge, waits for a trigger, then streams
// valid samples into BRAM as a one-shot or circular capture and reports status.
module snp_capture_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  input  logic [31:0]              ctrl_word,
  snp_capture_ctrl_if.slave        bus,
  output logic [31:0]              status
);
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_CNT   = (ADDR_WIDTH+1)'(1);

  state_t                state_q, state_d;
  logic                  arm_prev_q, arm_prev_d;
  logic                  trig_ext_q, trig_ext_d;
  logic                  circ_q, circ_d;
  logic                  wrapped_q, wrapped_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic arm_rise, arm_fall, hit;
  logic unused_ctrl_bits;

  assign unused_ctrl_bits = ^ctrl_word[31:3];

  assign arm_rise = ctrl_word[0] & ~arm_prev_q;
  assign arm_fall = ~ctrl_word[0] & arm_prev_q;
  assign hit      = bus.din_valid & (~trig_ext_q | bus.trig);

  always_comb begin
    state_d    = state_q;
    arm_prev_d = ctrl_word[0];
    trig_ext_d = trig_ext_q;
    circ_d     = circ_q;
    wrapped_d  = wrapped_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE: begin
        count_d   = '0;
        wrapped_d = 1'b0;
        wr_ptr_d  = '0;
        if (arm_rise) begin
          state_d    = S_ARMED;
          trig_ext_d = ctrl_word[1];
          circ_d     = ctrl_word[2];
        end
      end
      S_ARMED: begin
        // A hit in the same cycle as arm_fall still starts the capture.
        if (hit) begin
          we_d     = 1'b1;
          addr_d   = '0;
          data_d   = bus.din;
          wr_ptr_d = ONE_ADDR;
          count_d  = ONE_CNT;
          state_d  = S_CAPTURE;
        end else if (arm_fall) begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (bus.din_valid) begin
          we_d     = 1'b1;
          addr_d   = wr_ptr_q;
          data_d   = bus.din;
          wr_ptr_d = wr_ptr_q + ONE_ADDR;
          if (circ_q) begin
            count_d = {1'b0, wr_ptr_q + ONE_ADDR};
            if (wr_ptr_q == LAST_ADDR) begin
              wrapped_d = 1'b1;
            end
          end else begin
            count_d = count_q + ONE_CNT;
            if (wr_ptr_q == LAST_ADDR) begin
              state_d = S_DONE;
            end
          end
        end
        if (circ_q && arm_fall) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (arm_rise) begin
          state_d    = S_ARMED;
          trig_ext_d = ctrl_word[1];
          circ_d     = ctrl_word[2];
          count_d    = '0;
          wrapped_d  = 1'b0;
          wr_ptr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // arm_prev resets high so an arm level held through reset is not seen as an edge.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q    <= S_IDLE;
      arm_prev_q <= 1'b1;
      trig_ext_q <= 1'b0;
      circ_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      arm_prev_q <= arm_prev_d;
      trig_ext_q <= trig_ext_d;
      circ_q     <= circ_d;
      wrapped_q  <= wrapped_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign bus.bram_we   = we_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_data = data_q;

  assign status = {state_q == S_DONE,
                   (state_q == S_ARMED) || (state_q == S_CAPTURE),
                   wrapped_q,
                   13'd0,
                   16'(count_q)};
endmodule

// File: tb/tb_snp_capture_ctrl.sv
// Self-checking bench for snp_capture_ctrl: vector table, directed capture scenarios and
// random scenarios scored against a declarative model of which samples get captured.
module tb_snp_capture_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] ctrl_word;
  logic [31:0] status;

  snp_capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  snp_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .ctrl_word (ctrl_word),
    .bus       (bus),
    .status    (status)
  );

  always #5 user_clk = ~user_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          rst;
    logic [31:0] ctrl;
    logic [31:0] d;
    bit          v;
    bit          t;
    bit          e_we;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [31:0] e_status;
  } vec_t;

  typedef struct {
    bit          arm;
    bit          v;
    bit          t;
    logic [31:0] d;
  } cyc_t;

  vec_t tbl[16];
  cyc_t sc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input bit rst, input logic [31:0] ctrl, input logic [31:0] d,
                       input bit v, input bit t);
    @(negedge user_clk);
    user_rst      = rst;
    ctrl_word     = ctrl;
    bus.din       = d;
    bus.din_valid = v;
    bus.trig      = t;
    @(posedge user_clk);
    #1;
  endtask

  task automatic clean_reset();
    drive(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Model: the capture starts at the first hit after the arm edge unless arm drops first;
  // from there every valid sample is taken, up to DEPTH of them (one-shot) or through the
  // cycle arm drops (circular). Status follows from the number of samples taken.
  task automatic run_scenario(input string name, input bit ext, input bit circ,
                              output logic [31:0] final_status);
    int          len;
    int          hit;
    int          fall;
    int          n;
    bit          cap;
    bit          acc;
    logic [31:0] exp_st;
    len  = sc.size();
    hit  = -1;
    fall = len;
    n    = 0;
    for (int k = 1; k < len; k++) begin
      if (hit < 0 && sc[k].v && (!ext || sc[k].t)) hit = k;
      if (fall == len && !sc[k].arm) fall = k;
    end
    cap = (hit >= 0) && (hit <= fall);
    for (int k = 0; k < len; k++) begin
      drive(1'b0, {29'd0, circ, ext, sc[k].arm}, sc[k].d, sc[k].v, sc[k].t);
      acc = cap && (k >= hit) && sc[k].v && (circ ? (k <= fall) : (n < DEPTH));
      check({name, " we"}, 32'(bus.bram_we), 32'(acc));
      if (acc) begin
        check({name, " addr"}, 32'(bus.bram_addr), 32'(n % DEPTH));
        check({name, " data"}, bus.bram_data, sc[k].d);
        n++;
      end
      if (!cap && k >= fall)
        exp_st = 32'd0;
      else if (!circ)
        exp_st = ((n == DEPTH) ? 32'h8000_0000 : 32'h4000_0000) | 32'(n);
      else
        exp_st = ((k >= fall) ? 32'h8000_0000 : 32'h4000_0000)
               | ((n >= DEPTH) ? 32'h2000_0000 : 32'd0)
               | 32'(n % DEPTH);
      check({name, " status"}, status, exp_st);
    end
    final_status = status;
    $display("scenario %s ext=%0d circ=%0d cycles=%0d hit=%0d fall=%0d writes=%0d status=0x%08h",
             name, ext, circ, len, hit, fall, n, final_status);
    clean_reset();
  endtask

  task automatic push_cyc(input bit arm, input bit v, input bit t, input logic [31:0] d);
    cyc_t c;
    c.arm = arm;
    c.v   = v;
    c.t   = t;
    c.d   = d;
    sc.push_back(c);
  endtask

  initial begin
    logic [31:0] fs;
    int          len;
    int          fall;
    int          hit;
    bit          ext;
    bit          circ;

    // rst, ctrl, din, valid, trig | we, addr, data, status
    tbl[0]  = '{0, 32'd0, 32'h00, 0, 0, 0, 32'd0, 32'h00, 32'h0000_0000};
    tbl[1]  = '{0, 32'd3, 32'h11, 1, 1, 0, 32'd0, 32'h00, 32'h4000_0000};
    tbl[2]  = '{0, 32'd3, 32'h22, 0, 1, 0, 32'd0, 32'h00, 32'h4000_0000};
    tbl[3]  = '{0, 32'd3, 32'h33, 1, 0, 0, 32'd0, 32'h00, 32'h4000_0000};
    tbl[4]  = '{0, 32'd3, 32'hA5, 1, 1, 1, 32'd0, 32'hA5, 32'h4000_0001};
    tbl[5]  = '{0, 32'd3, 32'h55, 0, 0, 0, 32'd0, 32'h00, 32'h4000_0001};
    tbl[6]  = '{0, 32'd3, 32'h66, 1, 0, 1, 32'd1, 32'h66, 32'h4000_0002};
    tbl[7]  = '{0, 32'd1, 32'h77, 1, 1, 1, 32'd2, 32'h77, 32'h4000_0003};
    tbl[8]  = '{0, 32'd0, 32'h88, 1, 0, 1, 32'd3, 32'h88, 32'h4000_0004};
    tbl[9]  = '{0, 32'd3, 32'h99, 1, 0, 1, 32'd4, 32'h99, 32'h4000_0005};
    tbl[10] = '{1, 32'd3, 32'hAA, 1, 0, 0, 32'd0, 32'h00, 32'h0000_0000};
    tbl[11] = '{0, 32'd3, 32'hBB, 1, 1, 0, 32'd0, 32'h00, 32'h0000_0000};
    tbl[12] = '{0, 32'd0, 32'h00, 0, 0, 0, 32'd0, 32'h00, 32'h0000_0000};
    tbl[13] = '{0, 32'd1, 32'h00, 0, 0, 0, 32'd0, 32'h00, 32'h4000_0000};
    tbl[14] = '{0, 32'd0, 32'h00, 0, 0, 0, 32'd0, 32'h00, 32'h0000_0000};
    tbl[15] = '{0, 32'd0, 32'h00, 0, 0, 0, 32'd0, 32'h00, 32'h0000_0000};

    user_rst      = 1'b1;
    ctrl_word     = 32'd1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.trig      = 1'b0;

    // Arm held high through and after reset must not arm.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd1, 32'd0, 1'b1, 1'b0);
      check("rst status", status, 32'd0);
      check("rst we", 32'(bus.bram_we), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd1, 32'd0, 1'b1, 1'b0);
      check("held arm status", status, 32'd0);
      check("held arm we", 32'(bus.bram_we), 32'd0);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("arm low status", status, 32'd0);
    drive(1'b0, 32'd1, 32'd0, 1'b0, 1'b0);
    check("arm edge busy", status, 32'h4000_0000);
    $display("sequence reset-hold status=0x%08h", status);
    clean_reset();

    // External trigger, mid-capture mode/arm changes, reset mid-capture, abort.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].ctrl, tbl[i].d, tbl[i].v, tbl[i].t);
      check($sformatf("tbl%0d we", i), 32'(bus.bram_we), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        check($sformatf("tbl%0d addr", i), 32'(bus.bram_addr), tbl[i].e_addr);
        check($sformatf("tbl%0d data", i), bus.bram_data, tbl[i].e_data);
      end
      check($sformatf("tbl%0d status", i), status, tbl[i].e_status);
      $display("vector %0d rst=%0d ctrl=%0h din=%0h v=%0d t=%0d -> we=%0d addr=%0d data=%0h status=0x%08h",
               i, tbl[i].rst, tbl[i].ctrl, tbl[i].d, tbl[i].v, tbl[i].t,
               bus.bram_we, bus.bram_addr, bus.bram_data, status);
    end
    clean_reset();

    // One-shot immediate, sustained valid, counter data.
    sc.delete();
    for (int k = 0; k < 22; k++) push_cyc(1'b1, 1'b1, 1'b0, 32'(k));
    run_scenario("oneshot", 1'b0, 1'b0, fs);
    check("oneshot final", fs, 32'h8000_0010);

    // One-shot with valid toggling every cycle.
    sc.delete();
    for (int k = 0; k < 36; k++) push_cyc(1'b1, (k % 2) == 1, 1'b0, 32'h100 + 32'(k));
    run_scenario("toggle", 1'b0, 1'b0, fs);
    check("toggle final", fs, 32'h8000_0010);

    // Circular: 20 samples then arm drops.
    sc.delete();
    for (int k = 0; k < 24; k++) push_cyc(k < 21, (k >= 1) && (k <= 20), 1'b0, 32'h200 + 32'(k));
    run_scenario("circular", 1'b0, 1'b1, fs);
    check("circular final", fs, 32'hA000_0004);

    // Random scenarios.
    for (int s = 0; s < 24; s++) begin
      len  = $urandom_range(30, 56);
      ext  = 1'($urandom_range(0, 1));
      circ = 1'($urandom_range(0, 1));
      fall = $urandom_range(1, len);
      hit  = -1;
      sc.delete();
      for (int k = 0; k < len; k++)
        push_cyc(1'b1, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom);
      for (int k = 1; k < len; k++)
        if (hit < 0 && sc[k].v && (!ext || sc[k].t)) hit = k;
      if (circ && hit == fall) fall++;
      for (int k = 0; k < len; k++) sc[k].arm = (k < fall);
      run_scenario($sformatf("rand%0d", s), ext, circ, fs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
